// File: rtl/alu_ctrl_pkg.sv
// Shared ALU-control definitions: ALUop encodings, ALU select codes,
// family predicates and the multi-cycle tracker state encoding.
package alu_ctrl_pkg;

  localparam int unsigned CODE_W = 5;
  typedef logic [CODE_W-1:0] code_t;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam code_t SEL_AND    = 5'b00000;
  localparam code_t SEL_OR     = 5'b00001;
  localparam code_t SEL_ADD    = 5'b00010;
  localparam code_t SEL_XOR    = 5'b00011;
  localparam code_t SEL_SLL    = 5'b00100;
  localparam code_t SEL_SRL    = 5'b00101;
  localparam code_t SEL_SUB    = 5'b00110;
  localparam code_t SEL_SRA    = 5'b00111;
  localparam code_t SEL_SLT    = 5'b01000;
  localparam code_t SEL_SLTU   = 5'b01001;
  localparam code_t SEL_MUL    = 5'b10000;
  localparam code_t SEL_MULH   = 5'b10001;
  localparam code_t SEL_MULHSU = 5'b10010;
  localparam code_t SEL_MULHU  = 5'b10011;
  localparam code_t SEL_DIV    = 5'b10100;
  localparam code_t SEL_DIVU   = 5'b10101;
  localparam code_t SEL_REM    = 5'b10110;
  localparam code_t SEL_REMU   = 5'b10111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Base-ISA op for a funct3 when funct7[5] selects nothing special
  function automatic code_t base_code(input logic [2:0] funct3);
    code_t c;
    case (funct3)
      3'b000:  c = SEL_ADD;
      3'b001:  c = SEL_SLL;
      3'b010:  c = SEL_SLT;
      3'b011:  c = SEL_SLTU;
      3'b100:  c = SEL_XOR;
      3'b101:  c = SEL_SRL;
      3'b110:  c = SEL_OR;
      default: c = SEL_AND;
    endcase
    return c;
  endfunction

  function automatic logic is_mul_code(input code_t c);
    return c[4:2] == 3'b100;
  endfunction

  function automatic logic is_div_code(input code_t c);
    return c[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUop/funct decoder producing the ALU select code and
// op classification flags.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W    = 5,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic [1:0]       aluop,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             funct7_0,
  output logic [SEL_W-1:0] sel,
  output logic             illegal,
  output logic             is_mc,
  output logic             is_div
);

  code_t code;
  logic  bad;

  always_comb begin
    code = SEL_ADD;
    bad  = 1'b0;
    case (aluop)
      ALUOP_MEM: code = SEL_ADD;
      ALUOP_BR:  code = SEL_SUB;
      ALUOP_R: begin
        if (funct7_0) begin
          // M-extension: funct3 indexes MUL..REMU directly
          if (funct7_5 || !ENABLE_M) bad = 1'b1;
          else                       code = {2'b10, funct3};
        end else if (funct7_5) begin
          if      (funct3 == 3'b000) code = SEL_SUB;
          else if (funct3 == 3'b101) code = SEL_SRA;
          else                       bad  = 1'b1;
        end else begin
          code = base_code(funct3);
        end
      end
      default: begin
        // Immediate forms: funct7[5] only matters for the shift encodings
        if      (funct3 == 3'b001 && funct7_5) bad  = 1'b1;
        else if (funct3 == 3'b101 && funct7_5) code = SEL_SRA;
        else                                   code = base_code(funct3);
      end
    endcase
    if (bad) code = SEL_ADD;
  end

  assign sel     = SEL_W'(code);
  assign illegal = bad;
  assign is_mc   = !bad && (is_mul_code(code) || is_div_code(code));
  assign is_div  = !bad && is_div_code(code);

endmodule

// File: rtl/alu_ctrl_mc.sv
// Registered ALU control with multi-cycle MUL/DIV latency tracking and
// an in_ready/mc_busy/mc_done handshake toward the hazard unit.
module alu_ctrl_mc
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W    = 5,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned DIV_LAT  = 33,
  parameter int unsigned CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUop,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             funct7_0,
  output logic [SEL_W-1:0] alu_sel,
  output logic             sel_valid,
  output logic             illegal,
  output logic             is_mc,
  output logic             mc_busy,
  output logic             mc_done
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  logic [SEL_W-1:0] dec_sel;
  logic             dec_illegal, dec_is_mc, dec_is_div;

  alu_ctrl_dec #(
    .SEL_W    (SEL_W),
    .ENABLE_M (ENABLE_M)
  ) u_dec (
    .aluop    (ALUop),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .funct7_0 (funct7_0),
    .sel      (dec_sel),
    .illegal  (dec_illegal),
    .is_mc    (dec_is_mc),
    .is_div   (dec_is_div)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] alu_sel_d;
  logic             sel_valid_d, illegal_d, is_mc_d, mc_busy_d, mc_done_d;

  assign in_ready = (state_q == ST_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      alu_sel   <= SEL_W'(SEL_ADD);
      sel_valid <= 1'b0;
      illegal   <= 1'b0;
      is_mc     <= 1'b0;
      mc_busy   <= 1'b0;
      mc_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_sel   <= alu_sel_d;
      sel_valid <= sel_valid_d;
      illegal   <= illegal_d;
      is_mc     <= is_mc_d;
      mc_busy   <= mc_busy_d;
      mc_done   <= mc_done_d;
    end
  end

  // Accept in IDLE; in WAIT, flush beats count completion
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_sel_d   = alu_sel;
    sel_valid_d = 1'b0;
    illegal_d   = illegal;
    is_mc_d     = is_mc;
    mc_busy_d   = mc_busy;
    mc_done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          alu_sel_d   = dec_sel;
          sel_valid_d = 1'b1;
          illegal_d   = dec_illegal;
          is_mc_d     = dec_is_mc;
          if (dec_is_mc) begin
            state_d   = ST_WAIT;
            cnt_d     = dec_is_div ? DIV_CNT : MUL_CNT;
            mc_busy_d = 1'b1;
          end
        end
      end
      default: begin
        if (flush) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          mc_busy_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d   = ST_IDLE;
          mc_busy_d = 1'b0;
          mc_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Randomized + directed bench for alu_ctrl_mc, with and without the M extension,
// checked against a cycle-level behavioural model.
module tb_alu_ctrl_mc;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;
  localparam logic [4:0] BASE [8] = '{5'b00010, 5'b00100, 5'b01000, 5'b01001,
                                      5'b00011, 5'b00101, 5'b00001, 5'b00000};
  localparam logic [4:0] MD   [8] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011,
                                      5'b10100, 5'b10101, 5'b10110, 5'b10111};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, in_valid, funct7_5, funct7_0;
  logic [1:0] ALUop;
  logic [2:0] funct3;

  logic       rdy_m, sv_m, ill_m, mc_m, busy_m, done_m;
  logic [4:0] sel_m;
  logic       rdy_n, sv_n, ill_n, mc_n, busy_n, done_n;
  logic [4:0] sel_n;

  alu_ctrl_mc #(.SEL_W(5), .ENABLE_M(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_m),
    .ALUop(ALUop), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .alu_sel(sel_m), .sel_valid(sv_m), .illegal(ill_m), .is_mc(mc_m),
    .mc_busy(busy_m), .mc_done(done_m));

  alu_ctrl_mc #(.SEL_W(5), .ENABLE_M(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut_nm (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_n),
    .ALUop(ALUop), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .alu_sel(sel_n), .sel_valid(sv_n), .illegal(ill_n), .is_mc(mc_n),
    .mc_busy(busy_n), .mc_done(done_n));

  int checks = 0;
  int errors = 0;

  // Model state per instance: 0 = with M, 1 = without M
  int         rem   [2];
  logic [4:0] e_sel [2];
  bit         e_sv [2], e_ill [2], e_mc [2], e_done [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_dec(input bit en_m, input logic [1:0] op, input logic [2:0] f3,
                                  input logic f75, input logic f70,
                                  output logic [4:0] code, output bit ill, output int lat);
    ill  = 1'b0;
    lat  = 0;
    code = 5'b00010;
    if (op == 2'd0) code = 5'b00010;
    else if (op == 2'd1) code = 5'b00110;
    else if (op == 2'd2) begin
      if (f70) begin
        if (f75 || !en_m) ill = 1'b1;
        else begin
          code = MD[f3];
          lat  = (f3 < 3'd4) ? MUL_LAT : DIV_LAT;
        end
      end else if (f75) begin
        if (f3 == 3'd0) code = 5'b00110;
        else if (f3 == 3'd5) code = 5'b00111;
        else ill = 1'b1;
      end else code = BASE[f3];
    end else begin
      if (f3 == 3'd1 && f75) ill = 1'b1;
      else if (f3 == 3'd5 && f75) code = 5'b00111;
      else code = BASE[f3];
    end
    if (ill) code = 5'b00010;
  endfunction

  function automatic void model_edge();
    logic [4:0] c;
    bit         il;
    int         lt;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        rem[i] = 0; e_sel[i] = 5'b00010; e_sv[i] = 0; e_ill[i] = 0; e_mc[i] = 0; e_done[i] = 0;
      end else if (rem[i] > 0) begin
        e_sv[i] = 0;
        if (flush) begin
          rem[i] = 0; e_done[i] = 0;
        end else begin
          rem[i]--;
          e_done[i] = (rem[i] == 0);
        end
      end else begin
        e_done[i] = 0;
        e_sv[i]   = in_valid;
        if (in_valid) begin
          ref_dec(i == 0, ALUop, funct3, funct7_5, funct7_0, c, il, lt);
          e_sel[i] = c; e_ill[i] = il; e_mc[i] = (lt > 0); rem[i] = lt;
        end
      end
    end
  endfunction

  task automatic check_outputs();
    check("sel_m",   32'(sel_m),  32'(e_sel[0]));
    check("sv_m",    32'(sv_m),   32'(e_sv[0]));
    check("ill_m",   32'(ill_m),  32'(e_ill[0]));
    check("mc_m",    32'(mc_m),   32'(e_mc[0]));
    check("busy_m",  32'(busy_m), 32'(rem[0] > 0));
    check("done_m",  32'(done_m), 32'(e_done[0]));
    check("rdy_m",   32'(rdy_m),  32'(rem[0] == 0 && !rst));
    check("sel_n",   32'(sel_n),  32'(e_sel[1]));
    check("sv_n",    32'(sv_n),   32'(e_sv[1]));
    check("ill_n",   32'(ill_n),  32'(e_ill[1]));
    check("mc_n",    32'(mc_n),   32'(e_mc[1]));
    check("busy_n",  32'(busy_n), 32'(rem[1] > 0));
    check("done_n",  32'(done_n), 32'(e_done[1]));
    check("rdy_n",   32'(rdy_n),  32'(rem[1] == 0 && !rst));
  endtask

  // Drive one cycle's inputs at negedge, check, then advance the model at posedge
  task automatic cycle(input bit r, input bit fl, input bit v, input logic [1:0] op,
                       input logic [2:0] f3, input bit f75, input bit f70);
    @(negedge clk);
    rst = r; flush = fl; in_valid = v; ALUop = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 2'd0, 3'd0, 0, 0);
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; ALUop = 0; funct3 = 0; funct7_5 = 0; funct7_0 = 0;
    @(posedge clk);
    model_edge();
    cycle(1, 0, 1, 2'd2, 3'd0, 0, 1);
    #1 check("reset_sel", 32'(sel_m), 32'h02);

    // R-type sweep, funct7_0 = 0
    for (int f = 0; f < 16; f++) begin
      cycle(0, 0, 1, 2'd2, 3'(f >> 1), bit'(f & 1), 0);
      if (f == 11) #1 check("r_sra", 32'(sel_m), 32'h07);
      if (f == 5) begin
        #1 check("r_slt_f75_ill", 32'(ill_m), 32'h1);
        check("r_slt_f75_sel", 32'(sel_m), 32'h02);
      end
    end

    // MUL then ADD held; accepted on the cycle mc_done is high
    cycle(0, 0, 1, 2'd2, 3'd0, 0, 1);
    #1 check("mul_sel", 32'(sel_m), 32'h10);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 2'd0, 3'd0, 0, 0);
    #1 check("add_after_mul", 32'(sel_m), 32'h02);
    idle(1);

    // DIV full latency; the no-M instance flags illegal
    cycle(0, 0, 1, 2'd2, 3'd4, 0, 1);
    #1 check("div_ill_nm", 32'(ill_n), 32'h1);
    idle(DIV_LAT + 2);

    // I-type corner cases
    cycle(0, 0, 1, 2'd3, 3'd0, 1, 0);
    #1 check("i_add_f75", 32'(sel_m), 32'h02);
    cycle(0, 0, 1, 2'd3, 3'd5, 1, 1);
    #1 check("i_sra", 32'(sel_m), 32'h07);
    cycle(0, 0, 1, 2'd3, 3'd1, 1, 0);
    #1 check("i_sll_f75_ill", 32'(ill_m), 32'h1);

    // DIVU aborted by flush, then by reset
    cycle(0, 0, 1, 2'd2, 3'd5, 0, 1);
    idle(4);
    cycle(0, 1, 0, 2'd0, 3'd0, 0, 0);
    #1 check("flush_busy", 32'(busy_m), 32'h0);
    idle(3);
    cycle(0, 0, 1, 2'd2, 3'd5, 0, 1);
    idle(4);
    cycle(1, 0, 0, 2'd0, 3'd0, 0, 0);
    #1 check("rst_mid_busy", 32'(busy_m), 32'h0);
    idle(2);

    // Back-to-back single-cycle stream
    cycle(0, 0, 1, 2'd0, 3'd3, 1, 1);
    cycle(0, 0, 1, 2'd1, 3'd7, 0, 1);
    cycle(0, 0, 1, 2'd2, 3'd6, 0, 0);
    #1 check("stream_or", 32'(sel_m), 32'h01);
    idle(1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit         r, fl, v, f75, f70;
      logic [1:0] op;
      logic [2:0] f3;
      r   = ($urandom_range(0, 59) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      v   = ($urandom_range(0, 3) != 0);
      op  = 2'($urandom_range(0, 3));
      f3  = 3'($urandom_range(0, 7));
      f75 = bit'($urandom_range(0, 1));
      f70 = ($urandom_range(0, 2) == 0);
      // Immediate-bit cases outside the shift encodings are left undriven with f75=1
      if (op == 2'd3 && f3 != 3'd0 && f3 != 3'd1 && f3 != 3'd5) f75 = 0;
      cycle(r, fl, v, op, f3, f75, f70);
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
